// File: rtl/vm_pkg.sv
// Shared codes for the vending dispense block: item codes, change codes, FSM states.
package vm_pkg;

  typedef enum logic [1:0] {
    ITEM_NONE  = 2'b00,
    ITEM_COKE  = 2'b01,
    ITEM_PEPSI = 2'b10,
    ITEM_BAD   = 2'b11
  } item_e;

  localparam logic [1:0] CHG_0  = 2'b00;
  localparam logic [1:0] CHG_5  = 2'b01;
  localparam logic [1:0] CHG_10 = 2'b10;
  localparam logic [1:0] CHG_15 = 2'b11;

  localparam logic [2:0] ST_WAIT_REL = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_VEND     = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_EJECT    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vm_pulse_timer.sv
// Loadable down-counter; holds at zero and flags it.
module vm_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vm_dispense.sv
// Item motor and coin-change dispenser sequenced after each vending request.
//  state    | meaning
//  WAIT_REL | wait for y and c to return to 00
//  IDLE     | ready, captures the next request
//  VEND     | item motor on
//  GAP      | idle spacing before an eject pulse
//  EJECT    | one coin ejector on
//  DONE     | one-cycle completion
module vm_dispense
  import vm_pkg::*;
#(
  parameter int MOTOR_CYC = 8,
  parameter int EJECT_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int CNT_W     = 4,
  parameter int INIT5     = 4,
  parameter int INIT10    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       y,
  input  logic [1:0]       c,
  input  logic             refill5,
  input  logic             refill10,
  output logic [1:0]       motor,
  output logic             eject5,
  output logic             eject10,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cnt5,
  output logic [CNT_W-1:0] cnt10
);

  localparam int TW = $clog2(max3(MOTOR_CYC, EJECT_CYC, GAP_CYC) + 1);
  localparam logic [TW-1:0] T_MOTOR = TW'(MOTOR_CYC - 1);
  localparam logic [TW-1:0] T_EJECT = TW'(EJECT_CYC - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC - 1);

  logic [2:0]    state, state_nx;
  logic [1:0]    item;
  logic          tens_left, tens_nx, cur10, cur10_nx;
  logic [1:0]    fives_left, fives_nx;
  logic          cap, ej_start, tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val, tmr_count;
  logic          p_tens, p_short, plan_any, left_any, base_tens;
  logic [1:0]    p_fives, base_fives;
  logic          dec5, dec10;

  vm_pulse_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Prefer one 10-coin when available, cover the rest with 5-coins.
  assign p_tens   = c[1] && (cnt10 != '0);
  assign p_fives  = c - {p_tens, 1'b0};
  assign p_short  = CNT_W'(p_fives) > cnt5;
  assign plan_any = !p_short && (p_tens || (p_fives != 2'd0));
  assign left_any = tens_left || (fives_left != 2'd0);

  always_comb begin
    state_nx = state;
    cap      = 1'b0;
    ej_start = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_WAIT_REL: if (y == 2'b00 && c == 2'b00) state_nx = ST_IDLE;
      ST_IDLE: if ({y, c} != 4'd0) begin
        cap = 1'b1;
        if (y == ITEM_COKE || y == ITEM_PEPSI) begin
          state_nx = ST_VEND;  tmr_load = 1'b1;  tmr_val = T_MOTOR;
        end else if (plan_any) begin
          state_nx = ST_EJECT; tmr_load = 1'b1;  tmr_val = T_EJECT; ej_start = 1'b1;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_VEND, ST_EJECT: if (tmr_zero) begin
        if (left_any) begin
          state_nx = ST_GAP;   tmr_load = 1'b1;  tmr_val = T_GAP;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_GAP: if (tmr_zero) begin
        state_nx = ST_EJECT; tmr_load = 1'b1;  tmr_val = T_EJECT; ej_start = 1'b1;
      end
      ST_DONE: state_nx = ST_WAIT_REL;
      default: state_nx = ST_WAIT_REL;
    endcase
  end

  // The coin plan is consumed as each pulse starts, so left_any reflects what remains.
  always_comb begin
    base_tens  = cap ? (p_tens && !p_short) : tens_left;
    base_fives = cap ? (p_short ? 2'd0 : p_fives) : fives_left;
    tens_nx    = base_tens;
    fives_nx   = base_fives;
    cur10_nx   = cur10;
    if (ej_start) begin
      if (base_tens) begin
        tens_nx  = 1'b0;
        cur10_nx = 1'b1;
      end else begin
        fives_nx = base_fives - 2'd1;
        cur10_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_WAIT_REL;
      item       <= ITEM_NONE;
      tens_left  <= 1'b0;
      fives_left <= 2'd0;
      cur10      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      tens_left  <= tens_nx;
      fives_left <= fives_nx;
      cur10      <= cur10_nx;
      err        <= cap && ((y == ITEM_BAD) || p_short);
      if (cap) item <= y;
    end
  end

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] v,
                                                input logic inc, input logic dec);
    if (inc && !dec && v != '1)  return v + 1'b1;
    if (dec && !inc)             return v - 1'b1;
    return v;
  endfunction

  assign dec10 = (state == ST_EJECT) &&  cur10 && (tmr_count == T_EJECT);
  assign dec5  = (state == ST_EJECT) && !cur10 && (tmr_count == T_EJECT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt5  <= CNT_W'(INIT5);
      cnt10 <= CNT_W'(INIT10);
    end else begin
      cnt5  <= next_cnt(cnt5, refill5, dec5);
      cnt10 <= next_cnt(cnt10, refill10, dec10);
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign motor   = (state == ST_VEND) ? {item == ITEM_PEPSI, item == ITEM_COKE} : 2'b00;
  assign eject10 = (state == ST_EJECT) &&  cur10;
  assign eject5  = (state == ST_EJECT) && !cur10;

endmodule

// File: tb/tb_vm_dispense.sv
// Directed bench for vm_dispense with default parameters.
module tb_vm_dispense;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] y = 2'b00, c = 2'b00;
  logic       refill5 = 1'b0, refill10 = 1'b0;
  logic [1:0] motor;
  logic       eject5, eject10, busy, done, err;
  logic [3:0] cnt5, cnt10;
  logic [6:0] obs;

  int n_chk = 0;
  int n_err = 0;

  // {busy, motor[1:0], eject10, eject5, done, err}
  localparam logic [6:0] O_IDLE  = 7'b0_00_00_0_0;
  localparam logic [6:0] O_WAIT  = 7'b1_00_00_0_0;
  localparam logic [6:0] O_COKE  = 7'b1_01_00_0_0;
  localparam logic [6:0] O_PEPSI = 7'b1_10_00_0_0;
  localparam logic [6:0] O_E10   = 7'b1_00_10_0_0;
  localparam logic [6:0] O_E5    = 7'b1_00_01_0_0;
  localparam logic [6:0] O_DONE  = 7'b1_00_00_1_0;

  vm_dispense dut (
    .clk(clk), .reset(reset), .y(y), .c(c), .refill5(refill5), .refill10(refill10),
    .motor(motor), .eject5(eject5), .eject10(eject10), .busy(busy), .done(done),
    .err(err), .cnt5(cnt5), .cnt10(cnt10)
  );

  always #5 clk = ~clk;
  assign obs = {busy, motor, eject10, eject5, done, err};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input string tag, input logic [6:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, 32'(obs), 32'(exp));
      tick();
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_obs", 32'(obs), 32'(O_WAIT));
    chk("rst_cnt5", 32'(cnt5), 32'd4);
    chk("rst_cnt10", 32'(cnt10), 32'd4);
    tick(); tick();
    reset = 1'b1;
    chk("rel_busy", 32'(obs), 32'(O_WAIT));
    tick();
    chk("rel_idle", 32'(obs), 32'(O_IDLE));

    // coke, no change
    y = 2'b01; tick(); y = 2'b00;
    seg("coke_vend", O_COKE, 8);
    seg("coke_done", O_DONE, 1);
    tick();
    chk("coke_idle", 32'(obs), 32'(O_IDLE));
    chk("coke_cnt", 32'({cnt10, cnt5}), 32'h44);

    // pepsi with 15 change
    y = 2'b10; c = 2'b11; tick(); y = 2'b00; c = 2'b00;
    seg("p15_vend", O_PEPSI, 8);
    seg("p15_gap1", O_WAIT, 2);
    seg("p15_e10", O_E10, 4);
    seg("p15_gap2", O_WAIT, 2);
    seg("p15_e5", O_E5, 4);
    seg("p15_done", O_DONE, 1);
    tick();
    chk("p15_cnt", 32'({cnt10, cnt5}), 32'h33);

    // drain the 10-coins with change-only requests
    for (int k = 0; k < 3; k++) begin
      c = 2'b10; tick(); c = 2'b00;
      seg("drain_e10", O_E10, 4);
      seg("drain_done", O_DONE, 1);
      tick();
    end
    chk("drain_cnt", 32'({cnt10, cnt5}), 32'h03);

    c = 2'b10; tick(); c = 2'b00;
    seg("c10_e5a", O_E5, 4);
    seg("c10_gap", O_WAIT, 2);
    seg("c10_e5b", O_E5, 4);
    seg("c10_done", O_DONE, 1);
    tick();
    chk("c10_cnt", 32'({cnt10, cnt5}), 32'h01);

    // unpayable change: err and immediate done
    c = 2'b10; tick(); c = 2'b00;
    chk("short_err", 32'(obs), 32'(7'b1_00_00_1_1));
    tick(); tick();
    chk("short_idle", 32'(obs), 32'(O_IDLE));
    chk("short_cnt", 32'({cnt10, cnt5}), 32'h01);

    // held request must not re-vend
    y = 2'b01; tick();
    seg("held_vend", O_COKE, 8);
    seg("held_done", O_DONE, 1);
    seg("held_wait", O_WAIT, 4);
    y = 2'b00; tick();
    chk("held_idle", 32'(obs), 32'(O_IDLE));

    // invalid item with 5 change
    y = 2'b11; c = 2'b01; tick(); y = 2'b00; c = 2'b00;
    chk("bad_first", 32'(obs), 32'(7'b1_00_01_0_1));
    tick();
    seg("bad_e5", O_E5, 3);
    seg("bad_done", O_DONE, 1);
    tick();
    chk("bad_cnt", 32'({cnt10, cnt5}), 32'h00);

    // refill, then refill coincident with the eject decrement
    refill5 = 1'b1; tick(); tick(); refill5 = 1'b0;
    chk("refill5", 32'(cnt5), 32'd2);
    c = 2'b01; tick(); c = 2'b00;
    chk("co_first", 32'(obs), 32'(O_E5));
    refill5 = 1'b1; tick(); refill5 = 1'b0;
    chk("co_cnt5", 32'(cnt5), 32'd2);
    seg("co_e5", O_E5, 3);
    seg("co_done", O_DONE, 1);
    tick();
    chk("co_cnt5_end", 32'(cnt5), 32'd2);

    // saturation of the 10-coin counter
    refill10 = 1'b1;
    for (int k = 0; k < 17; k++) tick();
    refill10 = 1'b0;
    chk("sat10", 32'(cnt10), 32'd15);

    // reset during the third motor cycle
    y = 2'b01; tick(); y = 2'b00;
    tick(); tick();
    chk("mid_motor", 32'(obs), 32'(O_COKE));
    reset = 1'b0;
    #1;
    chk("mid_rst_obs", 32'(obs), 32'(O_WAIT));
    chk("mid_rst_cnt", 32'({cnt10, cnt5}), 32'h44);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rel_idle", 32'(obs), 32'(O_IDLE));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
